// File: rtl/commit_fwd_queue.sv
// ROB-head commit queue: DEPTH-entry FIFO plus last-committed register, searched by NUM_FWD ports.
// Optional perf counters are enabled by defining COMMIT_FWD_QUEUE_PERF_EN.
module commit_fwd_queue #(
   parameter int XLEN      = 64,
   parameter int IDX_W     = 6,
   parameter int PAYLOAD_W = 128,
   parameter int DEPTH     = 4,
   parameter int NUM_FWD   = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       rob_valid_i,
   output logic                       rob_ready_o,
   input  logic [IDX_W-1:0]           rob_idx_i,
   input  logic [XLEN-1:0]            rob_value_i,
   input  logic [PAYLOAD_W-1:0]       rob_payload_i,
   output logic                       cu_valid_o,
   input  logic                       cu_ready_i,
   output logic [IDX_W-1:0]           cu_idx_o,
   output logic [XLEN-1:0]            cu_value_o,
   output logic [PAYLOAD_W-1:0]       cu_payload_o,
   output logic                       comm_valid_o,
   output logic [IDX_W-1:0]           comm_idx_o,
   output logic [XLEN-1:0]            comm_value_o,
   output logic [PAYLOAD_W-1:0]       comm_payload_o,
   input  logic                       comm_clr_i,
   input  logic [NUM_FWD*IDX_W-1:0]   fwd_idx_i,
   output logic [NUM_FWD-1:0]         fwd_hit_o,
   output logic [NUM_FWD*XLEN-1:0]    fwd_value_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [31:0]                perf_full_o,
   output logic [31:0]                perf_stall_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IDX_W-1:0]     r_idx [DEPTH];
   logic [XLEN-1:0]      r_val [DEPTH];
   logic [PAYLOAD_W-1:0] r_pay [DEPTH];

   logic [PW-1:0]        r_rd_ptr;
   logic [PW-1:0]        r_wr_ptr;
   logic [CW-1:0]        r_count;

   logic                 r_comm_valid;
   logic [IDX_W-1:0]     r_comm_idx;
   logic [XLEN-1:0]      r_comm_val;
   logic [PAYLOAD_W-1:0] r_comm_pay;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic [PW-1:0]        w_age_slot [DEPTH];

   assign w_full      = (r_count == CW'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign rob_ready_o = !w_full && !flush_i;
   assign cu_valid_o  = !w_empty;
   assign w_push      = rob_valid_i && rob_ready_o;
   assign w_pop       = cu_valid_o && cu_ready_i && !flush_i;

   assign cu_idx_o     = r_idx[r_rd_ptr];
   assign cu_value_o   = r_val[r_rd_ptr];
   assign cu_payload_o = r_pay[r_rd_ptr];
   assign count_o      = r_count;

   assign comm_valid_o   = r_comm_valid;
   assign comm_idx_o     = r_comm_idx;
   assign comm_value_o   = r_comm_val;
   assign comm_payload_o = r_comm_pay;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Slot contents need no reset: liveness comes from the pointers and count.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_idx[r_wr_ptr] <= rob_idx_i;
         r_val[r_wr_ptr] <= rob_value_i;
         r_pay[r_wr_ptr] <= rob_payload_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_comm_valid <= 1'b0;
         r_comm_idx   <= '0;
         r_comm_val   <= '0;
         r_comm_pay   <= '0;
      end else if (flush_i) begin
         r_comm_valid <= 1'b0;
         r_comm_idx   <= '0;
         r_comm_val   <= '0;
         r_comm_pay   <= '0;
      end else if (w_pop) begin
         r_comm_valid <= 1'b1;
         r_comm_idx   <= r_idx[r_rd_ptr];
         r_comm_val   <= r_val[r_rd_ptr];
         r_comm_pay   <= r_pay[r_rd_ptr];
      end else if (comm_clr_i) begin
         r_comm_valid <= 1'b0;
         r_comm_idx   <= '0;
         r_comm_val   <= '0;
         r_comm_pay   <= '0;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_age_slot[i] = r_rd_ptr + PW'(i);
      end
   end

   // Lowest priority first; later (younger) matches overwrite older ones.
   always_comb begin
      fwd_hit_o   = '0;
      fwd_value_o = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
         if (r_comm_valid && r_comm_idx == fwd_idx_i[k*IDX_W +: IDX_W]) begin
            fwd_hit_o[k]                = 1'b1;
            fwd_value_o[k*XLEN +: XLEN] = r_comm_val;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count &&
                r_idx[w_age_slot[i]] == fwd_idx_i[k*IDX_W +: IDX_W]) begin
               fwd_hit_o[k]                = 1'b1;
               fwd_value_o[k*XLEN +: XLEN] = r_val[w_age_slot[i]];
            end
         end
      end
   end

`ifdef COMMIT_FWD_QUEUE_PERF_EN
   logic [31:0] r_perf_full;
   logic [31:0] r_perf_stall;

   // Saturating; flush deliberately leaves these alone.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_perf_full  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_full && r_perf_full != 32'hFFFF_FFFF)
            r_perf_full <= r_perf_full + 32'd1;
         if (cu_valid_o && !cu_ready_i && r_perf_stall != 32'hFFFF_FFFF)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_full_o  = r_perf_full;
   assign perf_stall_o = r_perf_stall;
`else
   assign perf_full_o  = '0;
   assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_commit_fwd_queue.sv
// Scoreboard bench for commit_fwd_queue: queue-based reference model checked every cycle.
module tb_commit_fwd_queue;

   localparam int XLEN  = 64;
   localparam int IW    = 6;
   localparam int PLW   = 128;
   localparam int DEPTH = 4;
   localparam int NF    = 2;

   typedef struct packed {
      logic [IW-1:0]   idx;
      logic [XLEN-1:0] val;
      logic [PLW-1:0]  pay;
   } ent_t;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b0;
   logic                 flush_i = 1'b0;
   logic                 rob_valid_i = 1'b0;
   logic                 rob_ready_o;
   logic [IW-1:0]        rob_idx_i = '0;
   logic [XLEN-1:0]      rob_value_i = '0;
   logic [PLW-1:0]       rob_payload_i = '0;
   logic                 cu_valid_o;
   logic                 cu_ready_i = 1'b0;
   logic [IW-1:0]        cu_idx_o;
   logic [XLEN-1:0]      cu_value_o;
   logic [PLW-1:0]       cu_payload_o;
   logic                 comm_valid_o;
   logic [IW-1:0]        comm_idx_o;
   logic [XLEN-1:0]      comm_value_o;
   logic [PLW-1:0]       comm_payload_o;
   logic                 comm_clr_i = 1'b0;
   logic [NF*IW-1:0]     fwd_idx_i = '0;
   logic [NF-1:0]        fwd_hit_o;
   logic [NF*XLEN-1:0]   fwd_value_o;
   logic [2:0]           count_o;
   logic [31:0]          perf_full_o;
   logic [31:0]          perf_stall_o;

   int n_cmp = 0;
   int n_err = 0;

   ent_t        m_q[$];
   logic        m_cv = 1'b0;
   ent_t        m_c  = '0;
   logic [31:0] m_pf = '0;
   logic [31:0] m_ps = '0;

   commit_fwd_queue dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .rob_valid_i(rob_valid_i), .rob_ready_o(rob_ready_o),
      .rob_idx_i(rob_idx_i), .rob_value_i(rob_value_i),
      .rob_payload_i(rob_payload_i),
      .cu_valid_o(cu_valid_o), .cu_ready_i(cu_ready_i),
      .cu_idx_o(cu_idx_o), .cu_value_o(cu_value_o),
      .cu_payload_o(cu_payload_o),
      .comm_valid_o(comm_valid_o), .comm_idx_o(comm_idx_o),
      .comm_value_o(comm_value_o), .comm_payload_o(comm_payload_o),
      .comm_clr_i(comm_clr_i), .fwd_idx_i(fwd_idx_i),
      .fwd_hit_o(fwd_hit_o), .fwd_value_o(fwd_value_o),
      .count_o(count_o), .perf_full_o(perf_full_o),
      .perf_stall_o(perf_stall_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [127:0] a,
                      input logic [127:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   // Monitor + reference model: compare current state, then advance model.
   always @(negedge clk_i) begin
      if (rst_i) begin
         chk("rst_count", count_o, 0);
         chk("rst_cu_valid", cu_valid_o, 0);
         chk("rst_rob_ready", rob_ready_o, 1);
         chk("rst_comm_valid", comm_valid_o, 0);
         chk("rst_comm_idx", comm_idx_o, 0);
         chk("rst_comm_value", comm_value_o, 0);
         chk("rst_comm_payload", comm_payload_o, 0);
         chk("rst_perf_full", perf_full_o, 0);
         chk("rst_perf_stall", perf_stall_o, 0);
         m_q.delete();
         m_cv = 1'b0;
         m_c  = '0;
         m_pf = '0;
         m_ps = '0;
      end else begin
         automatic int  sz  = m_q.size();
         automatic logic acc = (sz < DEPTH) && !flush_i;
         chk("rob_ready", rob_ready_o, acc);
         chk("count", count_o, sz);
         chk("cu_valid", cu_valid_o, sz > 0);
         if (cu_valid_o) begin
            if (sz == 0) begin
               chk("cu_unexpected", 1, 0);
            end else begin
               chk("cu_idx", cu_idx_o, m_q[0].idx);
               chk("cu_value", cu_value_o, m_q[0].val);
               chk("cu_payload", cu_payload_o, m_q[0].pay);
            end
         end
         chk("comm_valid", comm_valid_o, m_cv);
         chk("comm_idx", comm_idx_o, m_c.idx);
         chk("comm_value", comm_value_o, m_c.val);
         chk("comm_payload", comm_payload_o, m_c.pay);
         for (int k = 0; k < NF; k++) begin
            automatic logic [IW-1:0]   q  = fwd_idx_i[k*IW +: IW];
            automatic logic            eh = 1'b0;
            automatic logic [XLEN-1:0] ev = '0;
            for (int i = sz - 1; i >= 0; i--) begin
               if (!eh && m_q[i].idx == q) begin
                  eh = 1'b1;
                  ev = m_q[i].val;
               end
            end
            if (!eh && m_cv && m_c.idx == q) begin
               eh = 1'b1;
               ev = m_c.val;
            end
            chk($sformatf("fwd_hit%0d", k), fwd_hit_o[k], eh);
            chk($sformatf("fwd_value%0d", k), fwd_value_o[k*XLEN +: XLEN], ev);
         end
`ifdef COMMIT_FWD_QUEUE_PERF_EN
         chk("perf_full", perf_full_o, m_pf);
         chk("perf_stall", perf_stall_o, m_ps);
         if (sz == DEPTH && m_pf != 32'hFFFF_FFFF) m_pf = m_pf + 1;
         if (sz > 0 && !cu_ready_i && m_ps != 32'hFFFF_FFFF) m_ps = m_ps + 1;
`else
         chk("perf_full", perf_full_o, 0);
         chk("perf_stall", perf_stall_o, 0);
`endif
         if (flush_i) begin
            m_q.delete();
            m_cv = 1'b0;
            m_c  = '0;
         end else begin
            if (sz > 0 && cu_ready_i) begin
               m_c  = m_q.pop_front();
               m_cv = 1'b1;
            end else if (comm_clr_i) begin
               m_cv = 1'b0;
               m_c  = '0;
            end
            if (rob_valid_i && acc)
               m_q.push_back('{idx: rob_idx_i, val: rob_value_i,
                               pay: rob_payload_i});
         end
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drv(input logic v, input int idx, input logic [XLEN-1:0] val,
                      input logic rdy);
      rob_valid_i   = v;
      rob_idx_i     = IW'(idx);
      rob_value_i   = val;
      rob_payload_i = {$urandom, $urandom, $urandom, $urandom};
      cu_ready_i    = rdy;
   endtask

   task automatic idle();
      drv(1'b0, 0, '0, 1'b0);
      flush_i    = 1'b0;
      comm_clr_i = 1'b0;
   endtask

   initial begin
      int nxt;
      logic ok;
      idle();
      #1 rst_i = 1'b1;
      repeat (3) cyc();
      rst_i = 1'b0;
      cyc();

      // Fill to full with consumer stalled, then try a fifth push.
      for (int i = 3; i <= 6; i++) begin
         drv(1'b1, i, XLEN'(i * 16), 1'b0);
         cyc();
      end
      drv(1'b1, 13, 64'hDEAD, 1'b0);
      cyc();

      // Stream 7..12 through the full queue with the consumer draining.
      nxt = 7;
      for (int n = 0; n < 40 && nxt <= 12; n++) begin
         drv(1'b1, nxt, XLEN'(nxt * 16), 1'b1);
         @(negedge clk_i);
         ok = rob_ready_o;
         cyc();
         if (ok) nxt++;
      end
      chk("stream_done", nxt, 13);
      drv(1'b0, 0, '0, 1'b1);
      repeat (8) cyc();

      // Forward priority: FIFO copy of idx 5 beats the committed copy.
      drv(1'b1, 5, 64'h55, 1'b0);
      cyc();
      drv(1'b0, 0, '0, 1'b1);
      cyc();
      drv(1'b1, 5, 64'hAA, 1'b0);
      cyc();
      drv(1'b0, 0, '0, 1'b0);
      fwd_idx_i = {6'd9, 6'd5};
      repeat (2) cyc();
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;

      // Commit register lookup and clear.
      drv(1'b1, 3, 64'h10, 1'b0);
      fwd_idx_i = {6'd3, 6'd3};
      cyc();
      drv(1'b0, 0, '0, 1'b1);
      cyc();
      drv(1'b0, 0, '0, 1'b0);
      cyc();
      comm_clr_i = 1'b1;
      cyc();
      comm_clr_i = 1'b0;
      repeat (2) cyc();

      // Flush with three entries and a push pending.
      for (int i = 20; i < 23; i++) begin
         drv(1'b1, i, XLEN'(i), 1'b0);
         cyc();
      end
      drv(1'b1, 30, 64'h30, 1'b1);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      drv(1'b0, 0, '0, 1'b0);
      repeat (2) cyc();

      // Hold full and stalled for ten cycles.
      for (int i = 40; i < 44; i++) begin
         drv(1'b1, i, XLEN'(i), 1'b0);
         cyc();
      end
      drv(1'b0, 0, '0, 1'b0);
      repeat (10) cyc();
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;

      // Random traffic with a reset in the middle.
      for (int n = 0; n < 3000; n++) begin
         drv($urandom_range(0, 9) < 7, $urandom_range(0, 15),
             {$urandom, $urandom}, $urandom_range(0, 9) < 6);
         flush_i    = ($urandom_range(0, 49) == 0);
         comm_clr_i = ($urandom_range(0, 19) == 0);
         fwd_idx_i  = {IW'($urandom_range(0, 15)), IW'($urandom_range(0, 15))};
         if (n == 1500) rst_i = 1'b1;
         if (n == 1502) rst_i = 1'b0;
         cyc();
      end
      idle();
      repeat (3) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
